// File: rtl/ofdm_cp_framer.sv
// ofdm_cp_framer: OFDM frame assembler with a runtime cyclic prefix
// and a residual gearbox packing symbols into PHASES-wide beats.
module ofdm_cp_framer #(
  parameter int WIDTH     = 12,
  parameter int PHASES    = 64,
  parameter int FFTN      = 64,
  parameter int CPLEN     = 16,
  parameter int NUMSYM    = 12,
  parameter int HDR_BEATS = 5,
  parameter int GAP_BEATS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic [1:0]              cp_mode_i,
  input  logic                    hdr_valid_i,
  output logic                    hdr_ready_o,
  input  logic [WIDTH*PHASES-1:0] hdr_re_i,
  input  logic [WIDTH*PHASES-1:0] hdr_im_i,
  input  logic                    sym_valid_i,
  output logic                    sym_ready_o,
  input  logic [WIDTH*FFTN-1:0]   sym_re_i,
  input  logic [WIDTH*FFTN-1:0]   sym_im_i,
  output logic                    tx_valid_o,
  output logic [WIDTH*PHASES-1:0] tx_re_o,
  output logic [WIDTH*PHASES-1:0] tx_im_o,
  output logic                    tx_sof_o,
  output logic                    tx_eof_o,
  output logic                    underrun_o
);

  localparam int BW    = WIDTH * PHASES;
  localparam int DEPTH = PHASES - 1 + FFTN + CPLEN;
  localparam int EW    = DEPTH * WIDTH;
  localparam int RW    = $clog2(DEPTH + 1);
  localparam int NW    = $clog2(NUMSYM + 1);
  localparam int HW    = $clog2(HDR_BEATS + 1);
  localparam int GW    = $clog2(GAP_BEATS + 1);

  localparam logic [RW-1:0] P_C   = RW'(PHASES);
  localparam logic [RW-1:0] F_C   = RW'(FFTN);
  localparam logic [NW-1:0] NS_C  = NW'(NUMSYM);
  localparam logic [NW-1:0] NS1_C = NW'(NUMSYM - 1);
  localparam logic [HW-1:0] HB1_C = HW'(HDR_BEATS - 1);
  localparam logic [GW-1:0] GB1_C = GW'(GAP_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [RW-1:0] r_cp;
  logic [RW-1:0] r_cnt;
  logic [NW-1:0] r_scnt;
  logic [HW-1:0] r_hcnt;
  logic [GW-1:0] r_gcnt;
  logic [EW-1:0] r_buf_re;
  logic [EW-1:0] r_buf_im;
  logic          r_und;
  logic          r_tx_valid;
  logic [BW-1:0] r_tx_re;
  logic [BW-1:0] r_tx_im;
  logic          r_tx_sof;
  logic          r_tx_eof;

  logic [RW-1:0] w_cp_sel;
  logic [RW-1:0] w_len;
  logic [RW-1:0] w_cnt_ld;
  logic          w_pop;
  logic          w_more;
  logic          w_load;
  logic          w_tail;
  logic          w_pop_end;
  logic          w_load_end;
  logic [EW-1:0] w_ext_re;
  logic [EW-1:0] w_ext_im;
  logic [EW-1:0] w_mask;
  logic [EW-1:0] w_cat_re;
  logic [EW-1:0] w_cat_im;

  logic          w_tx_valid;
  logic [BW-1:0] w_tx_re;
  logic [BW-1:0] w_tx_im;
  logic          w_tx_sof;
  logic          w_tx_eof;
  logic [RW-1:0] w_cp_nx;
  logic [RW-1:0] w_cnt_nx;
  logic [NW-1:0] w_scnt_nx;
  logic [HW-1:0] w_hcnt_nx;
  logic [GW-1:0] w_gcnt_nx;
  logic [EW-1:0] w_buf_re_nx;
  logic [EW-1:0] w_buf_im_nx;
  logic          w_und_nx;

  always_comb begin
    w_cp_sel = '0;
    unique case (cp_mode_i)
      2'b00: w_cp_sel = '0;
      2'b01: w_cp_sel = RW'(CPLEN / 4);
      2'b10: w_cp_sel = RW'(CPLEN / 2);
      2'b11: w_cp_sel = RW'(CPLEN);
    endcase
  end

  assign w_len      = F_C + r_cp;
  assign w_cnt_ld   = r_cnt + w_len - P_C;
  assign w_pop      = (r_cnt >= P_C);
  assign w_more     = (r_scnt < NS_C);
  assign w_load     = !w_pop && w_more;
  assign w_tail     = !w_pop && !w_more && (r_cnt != '0);
  assign w_pop_end  = (r_cnt == P_C) && (r_scnt == NS_C);
  assign w_load_end = (w_cnt_ld == '0) && (r_scnt == NS1_C);

  // Prefix = symbol tail rotated to the front, body shifted up by cp
  assign w_ext_re = (EW'(sym_re_i) << (int'(r_cp) * WIDTH))
                  | (EW'(sym_re_i) >> ((FFTN - int'(r_cp)) * WIDTH));
  assign w_ext_im = (EW'(sym_im_i) << (int'(r_cp) * WIDTH))
                  | (EW'(sym_im_i) >> ((FFTN - int'(r_cp)) * WIDTH));

  assign w_mask   = ~({EW{1'b1}} << (int'(r_cnt) * WIDTH));
  assign w_cat_re = (w_ext_re << (int'(r_cnt) * WIDTH))
                  | (r_buf_re & w_mask);
  assign w_cat_im = (w_ext_im << (int'(r_cnt) * WIDTH))
                  | (r_buf_im & w_mask);

  assign hdr_ready_o = (r_state == S_HDR);
  assign sym_ready_o = (r_state == S_DATA) && w_load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (enable_i) w_state_nx = S_HDR;
      end
      S_HDR: begin
        if (!hdr_valid_i) w_state_nx = S_GAP;
        else if (r_hcnt == HB1_C) w_state_nx = S_DATA;
      end
      S_DATA: begin
        unique case (1'b1)
          w_pop: begin
            if (w_pop_end) w_state_nx = S_GAP;
          end
          w_load: begin
            if (!sym_valid_i || w_load_end) w_state_nx = S_GAP;
          end
          w_tail: w_state_nx = S_GAP;
          default: w_state_nx = S_GAP;
        endcase
      end
      S_GAP: begin
        if (r_gcnt == GB1_C) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_valid  = 1'b0;
    w_tx_re     = '0;
    w_tx_im     = '0;
    w_tx_sof    = 1'b0;
    w_tx_eof    = 1'b0;
    w_cp_nx     = r_cp;
    w_cnt_nx    = r_cnt;
    w_scnt_nx   = r_scnt;
    w_hcnt_nx   = r_hcnt;
    w_gcnt_nx   = '0;
    w_buf_re_nx = r_buf_re;
    w_buf_im_nx = r_buf_im;
    w_und_nx    = r_und;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nx    = '0;
        w_scnt_nx   = '0;
        w_hcnt_nx   = '0;
        w_buf_re_nx = '0;
        w_buf_im_nx = '0;
        if (enable_i) begin
          w_cp_nx  = w_cp_sel;
          w_und_nx = 1'b0;
        end
      end
      S_HDR: begin
        w_tx_valid = 1'b1;
        if (hdr_valid_i) begin
          w_tx_re   = hdr_re_i;
          w_tx_im   = hdr_im_i;
          w_tx_sof  = (r_hcnt == '0);
          w_hcnt_nx = r_hcnt + HW'(1);
        end else begin
          w_tx_eof = 1'b1;
          w_und_nx = 1'b1;
        end
      end
      S_DATA: begin
        unique case (1'b1)
          w_pop: begin
            w_tx_valid  = 1'b1;
            w_tx_re     = r_buf_re[BW-1:0];
            w_tx_im     = r_buf_im[BW-1:0];
            w_tx_eof    = w_pop_end;
            w_cnt_nx    = r_cnt - P_C;
            w_buf_re_nx = r_buf_re >> BW;
            w_buf_im_nx = r_buf_im >> BW;
          end
          w_load: begin
            w_tx_valid = 1'b1;
            if (sym_valid_i) begin
              w_tx_re     = w_cat_re[BW-1:0];
              w_tx_im     = w_cat_im[BW-1:0];
              w_tx_eof    = w_load_end;
              w_cnt_nx    = w_cnt_ld;
              w_scnt_nx   = r_scnt + NW'(1);
              w_buf_re_nx = w_cat_re >> BW;
              w_buf_im_nx = w_cat_im >> BW;
            end else begin
              w_tx_eof = 1'b1;
              w_und_nx = 1'b1;
            end
          end
          w_tail: begin
            w_tx_valid  = 1'b1;
            w_tx_re     = r_buf_re[BW-1:0] & w_mask[BW-1:0];
            w_tx_im     = r_buf_im[BW-1:0] & w_mask[BW-1:0];
            w_tx_eof    = 1'b1;
            w_cnt_nx    = '0;
            w_buf_re_nx = '0;
            w_buf_im_nx = '0;
          end
          default: ;
        endcase
      end
      S_GAP: begin
        w_gcnt_nx = r_gcnt + GW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cp       <= '0;
      r_cnt      <= '0;
      r_scnt     <= '0;
      r_hcnt     <= '0;
      r_gcnt     <= '0;
      r_buf_re   <= '0;
      r_buf_im   <= '0;
      r_und      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_re    <= '0;
      r_tx_im    <= '0;
      r_tx_sof   <= 1'b0;
      r_tx_eof   <= 1'b0;
    end else begin
      r_cp       <= w_cp_nx;
      r_cnt      <= w_cnt_nx;
      r_scnt     <= w_scnt_nx;
      r_hcnt     <= w_hcnt_nx;
      r_gcnt     <= w_gcnt_nx;
      r_buf_re   <= w_buf_re_nx;
      r_buf_im   <= w_buf_im_nx;
      r_und      <= w_und_nx;
      r_tx_valid <= w_tx_valid;
      r_tx_re    <= w_tx_re;
      r_tx_im    <= w_tx_im;
      r_tx_sof   <= w_tx_sof;
      r_tx_eof   <= w_tx_eof;
    end
  end

  assign tx_valid_o = r_tx_valid;
  assign tx_re_o    = r_tx_re;
  assign tx_im_o    = r_tx_im;
  assign tx_sof_o   = r_tx_sof;
  assign tx_eof_o   = r_tx_eof;
  assign underrun_o = r_und;

endmodule

// File: tb/tb_ofdm_cp_framer.sv
// tb_ofdm_cp_framer: directed bench for the OFDM CP framer
// covering CP modes, underrun, back-to-back frames and reset.
module tb_ofdm_cp_framer;

  localparam int W  = 12;
  localparam int P  = 64;
  localparam int F  = 64;
  localparam int NS = 12;
  localparam int HB = 5;
  localparam int BW = W * P;
  localparam int SD = W * F;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          enable_i;
  logic [1:0]    cp_mode_i;
  logic          hdr_valid_i;
  logic          hdr_ready_o;
  logic [BW-1:0] hdr_re_i;
  logic [BW-1:0] hdr_im_i;
  logic          sym_valid_i;
  logic          sym_ready_o;
  logic [SD-1:0] sym_re_i;
  logic [SD-1:0] sym_im_i;
  logic          tx_valid_o;
  logic [BW-1:0] tx_re_o;
  logic [BW-1:0] tx_im_o;
  logic          tx_sof_o;
  logic          tx_eof_o;
  logic          underrun_o;

  ofdm_cp_framer dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .cp_mode_i   (cp_mode_i),
    .hdr_valid_i (hdr_valid_i),
    .hdr_ready_o (hdr_ready_o),
    .hdr_re_i    (hdr_re_i),
    .hdr_im_i    (hdr_im_i),
    .sym_valid_i (sym_valid_i),
    .sym_ready_o (sym_ready_o),
    .sym_re_i    (sym_re_i),
    .sym_im_i    (sym_im_i),
    .tx_valid_o  (tx_valid_o),
    .tx_re_o     (tx_re_o),
    .tx_im_o     (tx_im_o),
    .tx_sof_o    (tx_sof_o),
    .tx_eof_o    (tx_eof_o),
    .underrun_o  (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int idle_bad = 0;
  int hidx = 0;
  int sidx = 0;
  int drop_at = -1;

  logic [BW-1:0] q_re[$];
  logic [BW-1:0] q_im[$];
  bit            q_sof[$];
  bit            q_eof[$];
  bit            q_und[$];
  int            q_cyc[$];
  bit            und_log[0:8191];

  task automatic chk(input string tag, input logic [BW-1:0] got,
                     input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SD-1:0] sym_vec(input int s, input bit im);
    logic [SD-1:0] r;
    logic [W-1:0]  v;
    r = '0;
    for (int k = 0; k < F; k++) begin
      v = W'(s * 64 + k);
      if (im) v = v ^ 12'hA5A;
      r[k*W +: W] = v;
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] hdr_vec(input int h, input bit im);
    logic [BW-1:0] r;
    logic [W-1:0]  v;
    r = '0;
    for (int k = 0; k < P; k++) begin
      v = W'(2048 + h * 64 + k);
      if (im) v = v ^ 12'h3C3;
      r[k*W +: W] = v;
    end
    return r;
  endfunction

  // Expected data beat b: walk the extended-symbol stream sample by sample
  function automatic logic [BW-1:0] exp_data(input int b, input int cp,
                                             input bit im);
    logic [BW-1:0] r;
    logic [W-1:0]  v;
    int L, n, s, o, k;
    r = '0;
    L = F + cp;
    for (int l = 0; l < P; l++) begin
      n = b * P + l;
      v = '0;
      if (n < NS * L) begin
        s = n / L;
        o = n % L;
        k = (o < cp) ? (F - cp + o) : (o - cp);
        v = W'(s * 64 + k);
        if (im) v = v ^ 12'hA5A;
      end
      r[l*W +: W] = v;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] lane(input logic [BW-1:0] vec,
                                        input int l);
    return vec[l*W +: W];
  endfunction

  task automatic tick();
    @(negedge clk_i);
    cyc++;
    if (cyc < 8192) und_log[cyc] = underrun_o;
    if (tx_valid_o) begin
      q_re.push_back(tx_re_o);
      q_im.push_back(tx_im_o);
      q_sof.push_back(tx_sof_o);
      q_eof.push_back(tx_eof_o);
      q_und.push_back(underrun_o);
      q_cyc.push_back(cyc);
    end else if (tx_sof_o || tx_eof_o || tx_re_o != '0 || tx_im_o != '0) begin
      idle_bad++;
    end
    if (!hdr_ready_o) hidx = 0;
    hdr_re_i    = hdr_vec(hidx, 1'b0);
    hdr_im_i    = hdr_vec(hidx, 1'b1);
    hdr_valid_i = 1'b1;
    if (hdr_ready_o) begin
      sidx = 0;
      hidx = (hidx + 1) % HB;
    end
    sym_re_i    = sym_vec(sidx, 1'b0);
    sym_im_i    = sym_vec(sidx, 1'b1);
    sym_valid_i = (sidx != drop_at);
    if (sym_ready_o && !sym_valid_i) drop_at = -1;
    else if (sym_ready_o) sidx++;
  endtask

  task automatic clear_log();
    q_re.delete();
    q_im.delete();
    q_sof.delete();
    q_eof.delete();
    q_und.delete();
    q_cyc.delete();
  endtask

  task automatic wait_hdr();
    int n = 0;
    while (!hdr_ready_o && n < 20) begin
      tick();
      n++;
    end
    chk("hdr_start", BW'(hdr_ready_o), BW'(1));
  endtask

  task automatic wait_beats(input int nb, input int lim);
    int n = 0;
    while (q_re.size() < nb && n < lim) begin
      tick();
      n++;
    end
    chk("beat_wait", BW'(q_re.size() >= nb), BW'(1));
  endtask

  task automatic run_one(input logic [1:0] mode);
    clear_log();
    cp_mode_i = mode;
    enable_i  = 1'b1;
    wait_hdr();
    enable_i = 1'b0;
    repeat (45) tick();
  endtask

  task automatic check_frame(input int base, input int cp, input string nm);
    int L, nd, nb, ne, nsof;
    L  = F + cp;
    nd = (NS * L + P - 1) / P;
    nb = HB + nd;
    if (q_re.size() < base + nb) begin
      chk({nm, "_len"}, BW'(q_re.size()), BW'(base + nb));
    end else begin
      chk({nm, "_sof"}, BW'(q_sof[base]), BW'(1));
      chk({nm, "_eof"}, BW'(q_eof[base+nb-1]), BW'(1));
      chk({nm, "_span"}, BW'(q_cyc[base+nb-1] - q_cyc[base]), BW'(nb - 1));
      for (int h = 0; h < HB; h++) begin
        chk($sformatf("%s_hre%0d", nm, h), q_re[base+h], hdr_vec(h, 1'b0));
        chk($sformatf("%s_him%0d", nm, h), q_im[base+h], hdr_vec(h, 1'b1));
      end
      for (int b = 0; b < nd; b++) begin
        chk($sformatf("%s_dre%0d", nm, b), q_re[base+HB+b],
            exp_data(b, cp, 1'b0));
        chk($sformatf("%s_dim%0d", nm, b), q_im[base+HB+b],
            exp_data(b, cp, 1'b1));
      end
      ne   = 0;
      nsof = 0;
      for (int i = base; i < base + nb; i++) begin
        ne   += int'(q_eof[i]);
        nsof += int'(q_sof[i]);
      end
      chk({nm, "_neof"}, BW'(ne), BW'(1));
      chk({nm, "_nsof"}, BW'(nsof), BW'(1));
    end
  endtask

  initial begin
    int c, held;
    rst_ni      = 1'b0;
    enable_i    = 1'b0;
    cp_mode_i   = 2'b00;
    hdr_valid_i = 1'b0;
    hdr_re_i    = '0;
    hdr_im_i    = '0;
    sym_valid_i = 1'b0;
    sym_re_i    = '0;
    sym_im_i    = '0;
    repeat (3) tick();
    chk("rst_valid", BW'(tx_valid_o), BW'(0));
    chk("rst_re", tx_re_o, '0);
    chk("rst_im", tx_im_o, '0);
    chk("rst_sofeof", BW'({tx_sof_o, tx_eof_o}), BW'(0));
    chk("rst_rdy", BW'({hdr_ready_o, sym_ready_o}), BW'(0));
    chk("rst_und", BW'(underrun_o), BW'(0));
    rst_ni = 1'b1;
    repeat (2) tick();

    // Full prefix: 80-sample symbols fill 15 beats exactly
    run_one(2'b11);
    chk("cp3_cnt", BW'(q_re.size()), BW'(20));
    check_frame(0, 16, "cp3");
    if (q_re.size() >= 20) begin
      chk("cp3_l0", BW'(lane(q_re[5], 0)), BW'(48));
      chk("cp3_l15", BW'(lane(q_re[5], 15)), BW'(63));
      chk("cp3_l16", BW'(lane(q_re[5], 16)), BW'(0));
      chk("cp3_l63", BW'(lane(q_re[5], 63)), BW'(47));
      chk("cp3_eof19", BW'(q_eof[19]), BW'(1));
    end
    chk("cp3_r0", BW'(dut.r_cnt), BW'(0));

    run_one(2'b00);
    chk("cp0_cnt", BW'(q_re.size()), BW'(17));
    check_frame(0, 0, "cp0");
    if (q_re.size() >= 17) begin
      chk("cp0_s0", q_re[5], BW'(sym_vec(0, 1'b0)));
      chk("cp0_s11", q_re[16], BW'(sym_vec(11, 1'b0)));
      chk("cp0_eof", BW'(q_eof[16]), BW'(1));
    end

    // 816 samples: 12 full beats plus a 48-lane tail
    run_one(2'b01);
    chk("cp1_cnt", BW'(q_re.size()), BW'(18));
    check_frame(0, 4, "cp1");
    if (q_re.size() >= 18) begin
      chk("cp1_b1l3", BW'(lane(q_re[6], 3)), BW'(63));
      chk("cp1_b1l4", BW'(lane(q_re[6], 4)), BW'(124));
      chk("cp1_tl47", BW'(lane(q_re[17], 47)), BW'(767));
      chk("cp1_tl48", BW'(lane(q_re[17], 48)), BW'(0));
      chk("cp1_tpad", q_re[17] >> (48 * W), '0);
    end

    // Symbol 7 withheld: zero eof beat, sticky flag, then a clean frame
    clear_log();
    cp_mode_i = 2'b11;
    drop_at   = 7;
    enable_i  = 1'b1;
    wait_hdr();
    wait_beats(15, 100);
    enable_i = 1'b0;
    repeat (40) tick();
    chk("ur_cnt", BW'(q_re.size()), BW'(34));
    if (q_re.size() >= 34) begin
      chk("ur_d7", q_re[12], exp_data(7, 16, 1'b0));
      chk("ur_zre", q_re[13], '0);
      chk("ur_zim", q_im[13], '0);
      chk("ur_eof", BW'({q_eof[12], q_eof[13]}), BW'(1));
      chk("ur_flag", BW'(q_und[13]), BW'(1));
      c    = q_cyc[13];
      held = 0;
      for (int i = 1; i <= 4; i++) held += int'(und_log[c+i]);
      chk("ur_held", BW'(held), BW'(4));
      chk("ur_clr", BW'(und_log[c+5]), BW'(0));
      chk("ur_gap", BW'(q_cyc[14] - c), BW'(6));
      chk("ur_nflag", BW'(q_und[14]), BW'(0));
      check_frame(14, 16, "ur2");
    end

    // Back-to-back frames; cp change lands on the third frame
    clear_log();
    cp_mode_i = 2'b11;
    enable_i  = 1'b1;
    wait_hdr();
    wait_beats(25, 100);
    cp_mode_i = 2'b00;
    wait_beats(41, 100);
    enable_i = 1'b0;
    repeat (40) tick();
    chk("b2b_cnt", BW'(q_re.size()), BW'(57));
    if (q_re.size() >= 57) begin
      chk("b2b_sp1", BW'(q_cyc[20] - q_cyc[0]), BW'(25));
      chk("b2b_sp2", BW'(q_cyc[40] - q_cyc[20]), BW'(25));
      check_frame(0, 16, "b2b1");
      check_frame(20, 16, "b2b2");
      check_frame(40, 0, "b2b3");
    end

    // Asynchronous reset with residual samples held
    clear_log();
    cp_mode_i = 2'b11;
    enable_i  = 1'b1;
    wait_hdr();
    enable_i = 1'b0;
    wait_beats(7, 30);
    chk("mr_r", BW'(dut.r_cnt), BW'(32));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mr_valid", BW'(tx_valid_o), BW'(0));
    chk("mr_re", tx_re_o, '0);
    chk("mr_im", tx_im_o, '0);
    chk("mr_flags", BW'({tx_sof_o, tx_eof_o, underrun_o}), BW'(0));
    chk("mr_rdy", BW'({hdr_ready_o, sym_ready_o}), BW'(0));
    chk("mr_rclr", BW'(dut.r_cnt), BW'(0));
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    run_one(2'b11);
    chk("pr_cnt", BW'(q_re.size()), BW'(20));
    check_frame(0, 16, "pr");

    chk("idle_zero", BW'(idle_bad), BW'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
